// File: rtl/game_pkg.sv
// Shared types and constants for the pong game-flow logic.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        POINT     = 3'd4,
        GAME_OVER = 3'd5
    } match_state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    localparam int DEFAULT_WIN_POINTS = 9;

    // Score increment that sticks at the limit instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick prescaler: one-cycle tick every TICK_DIV enabled cycles, with sync clear.
module tick_gen #(
    parameter int TICK_DIV = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Kept independent of clr_i so the FSM can use tick to decide a state change.
    assign tick_o = en_i && (count_q == LAST);

endmodule

// File: rtl/match_seq.sv
// Pong game-flow sequencer: serve countdown, play/pause, scoring, point hold and winner.
module match_seq
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 65_000_000,
    parameter int COUNTDOWN_LEN = 3,
    parameter int POINT_HOLD    = 2,
    parameter int WIN_POINTS    = DEFAULT_WIN_POINTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic       ball_run,
    output logic       ball_serve,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [3:0] countdown,
    output logic [2:0] state_o,
    output logic [1:0] winner
);

    localparam logic [3:0] CD_LEN = 4'(COUNTDOWN_LEN);
    localparam logic [3:0] WIN    = 4'(WIN_POINTS);
    localparam int HW = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(POINT_HOLD - 1);

    match_state_t  state_q, state_d;
    logic [3:0]    score_p1_q, score_p1_d;
    logic [3:0]    score_p2_q, score_p2_d;
    logic [3:0]    countdown_q, countdown_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    winner_q, winner_d;
    logic          serve_dir_q, serve_dir_d;
    logic          ball_run_q, ball_run_d;
    logic          ball_serve_q, ball_serve_d;
    logic          tick;
    logic [3:0]    p1_next, p2_next;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   ((state_q == COUNTDOWN) || (state_q == POINT)),
        .clr_i  (state_d != state_q),
        .tick_o (tick)
    );

    assign p1_next = sat_inc(score_p1_q, WIN);
    assign p2_next = sat_inc(score_p2_q, WIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            score_p1_q   <= '0;
            score_p2_q   <= '0;
            countdown_q  <= '0;
            hold_q       <= '0;
            winner_q     <= WINNER_NONE;
            serve_dir_q  <= 1'b0;
            ball_run_q   <= 1'b0;
            ball_serve_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            countdown_q  <= countdown_d;
            hold_q       <= hold_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            ball_run_q   <= ball_run_d;
            ball_serve_q <= ball_serve_d;
        end
    end

    // A point in PLAY outranks pause, and player 1 outranks player 2.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, GAME_OVER: if (start_pulse) state_d = COUNTDOWN;
            COUNTDOWN: if (tick && countdown_q == 4'd1) state_d = PLAY;
            PLAY: begin
                if (point_p1)         state_d = (p1_next == WIN) ? GAME_OVER : POINT;
                else if (point_p2)    state_d = (p2_next == WIN) ? GAME_OVER : POINT;
                else if (pause_pulse) state_d = PAUSED;
            end
            PAUSED: if (pause_pulse) state_d = PLAY;
            POINT: if (tick && hold_q == HOLD_LAST) state_d = COUNTDOWN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        score_p1_d   = score_p1_q;
        score_p2_d   = score_p2_q;
        countdown_d  = countdown_q;
        hold_d       = hold_q;
        winner_d     = winner_q;
        serve_dir_d  = serve_dir_q;
        ball_serve_d = 1'b0;
        ball_run_d   = (state_d == PLAY);
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_pulse) begin
                    score_p1_d  = '0;
                    score_p2_d  = '0;
                    winner_d    = WINNER_NONE;
                    serve_dir_d = 1'b0;
                    countdown_d = CD_LEN;
                end
            end
            COUNTDOWN: begin
                if (tick) begin
                    countdown_d = countdown_q - 4'd1;
                    if (countdown_q == 4'd1) ball_serve_d = 1'b1;
                end
            end
            PLAY: begin
                hold_d = '0;
                if (point_p1) begin
                    score_p1_d  = p1_next;
                    serve_dir_d = 1'b1;
                    if (p1_next == WIN) winner_d = WINNER_P1;
                end else if (point_p2) begin
                    score_p2_d  = p2_next;
                    serve_dir_d = 1'b0;
                    if (p2_next == WIN) winner_d = WINNER_P2;
                end
            end
            POINT: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d      = '0;
                        countdown_d = CD_LEN;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign ball_run   = ball_run_q;
    assign ball_serve = ball_serve_q;
    assign serve_dir  = serve_dir_q;
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign countdown  = countdown_q;
    assign state_o    = state_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_match_seq.sv
// Directed self-checking bench for match_seq with a short tick period.
module tb_match_seq;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startPulse = 1'b0;
    logic       pausePulse = 1'b0;
    logic       pointP1 = 1'b0;
    logic       pointP2 = 1'b0;
    logic       ballRun, ballServe, serveDir;
    logic [3:0] scoreP1, scoreP2, countdown;
    logic [2:0] stateO;
    logic [1:0] winner;

    int tests = 0;
    int fails = 0;

    match_seq #(
        .TICK_DIV(4), .COUNTDOWN_LEN(3), .POINT_HOLD(2), .WIN_POINTS(3)
    ) dut (
        .clk(clk), .rst(rst),
        .start_pulse(startPulse), .pause_pulse(pausePulse),
        .point_p1(pointP1), .point_p2(pointP2),
        .ball_run(ballRun), .ball_serve(ballServe), .serve_dir(serveDir),
        .score_p1(scoreP1), .score_p2(scoreP2), .countdown(countdown),
        .state_o(stateO), .winner(winner)
    );

    always #5 clk = ~clk;

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic doStart();
        startPulse = 1'b1;
        step(1);
        startPulse = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        tests++;
        if ({ballRun, ballServe, serveDir, scoreP1, scoreP2, countdown, stateO, winner} !== 20'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got run=%b serve=%b dir=%b s1=%0d s2=%0d cd=%0d st=%0d win=%b want all 0",
                     ballRun, ballServe, serveDir, scoreP1, scoreP2, countdown, stateO, winner);
        end
    endtask

    task automatic test_start();
        int serveSeen;
        doStart();
        serveSeen = 0;
        for (int k = 0; k < 12; k++) begin
            if (ballServe) serveSeen++;
            if (k % 4 == 0) begin
                tests++;
                if (countdown !== 4'(3 - k / 4) || stateO !== COUNTDOWN || ballRun !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL start_countdown k=%0d got cd=%0d st=%0d run=%b want cd=%0d st=1 run=0",
                             k, countdown, stateO, ballRun, 3 - k / 4);
                end
            end
            step(1);
        end
        tests++;
        if (serveSeen !== 0) begin
            fails++;
            $display("[TB] FAIL early_serve got %0d pulses want 0", serveSeen);
        end
        tests++;
        if (ballServe !== 1'b1 || serveDir !== 1'b0 || stateO !== PLAY || countdown !== 4'd0) begin
            fails++;
            $display("[TB] FAIL first_serve got serve=%b dir=%b st=%0d cd=%0d want 1 0 2 0",
                     ballServe, serveDir, stateO, countdown);
        end
        step(1);
        tests++;
        if (ballServe !== 1'b0 || ballRun !== 1'b1) begin
            fails++;
            $display("[TB] FAIL after_serve got serve=%b run=%b want 0 1", ballServe, ballRun);
        end
    endtask

    task automatic test_point();
        int runSeen;
        pointP2 = 1'b1;
        step(1);
        pointP2 = 1'b0;
        tests++;
        if (scoreP2 !== 4'd1 || scoreP1 !== 4'd0 || serveDir !== 1'b0) begin
            fails++;
            $display("[TB] FAIL point_p2_score got s1=%0d s2=%0d dir=%b want 0 1 0", scoreP1, scoreP2, serveDir);
        end
        runSeen = 0;
        for (int k = 0; k < 8; k++) begin
            if (ballRun !== 1'b0 || stateO !== POINT) runSeen++;
            step(1);
        end
        tests++;
        if (runSeen !== 0) begin
            fails++;
            $display("[TB] FAIL point_hold got %0d bad cycles want 0", runSeen);
        end
        tests++;
        if (stateO !== COUNTDOWN || countdown !== 4'd3) begin
            fails++;
            $display("[TB] FAIL hold_exit got st=%0d cd=%0d want 1 3", stateO, countdown);
        end
        step(12);
        tests++;
        if (ballServe !== 1'b1 || serveDir !== 1'b0 || stateO !== PLAY) begin
            fails++;
            $display("[TB] FAIL reserve got serve=%b dir=%b st=%0d want 1 0 2", ballServe, serveDir, stateO);
        end
        step(1);
    endtask

    task automatic test_simultaneous();
        pointP1 = 1'b1;
        pointP2 = 1'b1;
        step(1);
        pointP1 = 1'b0;
        pointP2 = 1'b0;
        tests++;
        if (scoreP1 !== 4'd1 || scoreP2 !== 4'd1 || serveDir !== 1'b1 || stateO !== POINT) begin
            fails++;
            $display("[TB] FAIL simultaneous got s1=%0d s2=%0d dir=%b st=%0d want 1 1 1 4",
                     scoreP1, scoreP2, serveDir, stateO);
        end
        step(20);
        tests++;
        if (ballServe !== 1'b1 || serveDir !== 1'b1) begin
            fails++;
            $display("[TB] FAIL serve_toward_p2 got serve=%b dir=%b want 1 1", ballServe, serveDir);
        end
        step(1);
    endtask

    task automatic test_pause();
        pausePulse = 1'b1;
        step(1);
        pausePulse = 1'b0;
        tests++;
        if (stateO !== PAUSED || ballRun !== 1'b0) begin
            fails++;
            $display("[TB] FAIL pause_enter got st=%0d run=%b want 3 0", stateO, ballRun);
        end
        pointP1 = 1'b1;
        step(1);
        pointP1 = 1'b0;
        step(3);
        tests++;
        if (scoreP1 !== 4'd1 || scoreP2 !== 4'd1 || stateO !== PAUSED) begin
            fails++;
            $display("[TB] FAIL paused_point got s1=%0d s2=%0d st=%0d want 1 1 3", scoreP1, scoreP2, stateO);
        end
        pausePulse = 1'b1;
        step(1);
        pausePulse = 1'b0;
        tests++;
        if (stateO !== PLAY || ballRun !== 1'b1) begin
            fails++;
            $display("[TB] FAIL resume got st=%0d run=%b want 2 1", stateO, ballRun);
        end
    endtask

    task automatic test_win_restart();
        doReset();
        doStart();
        step(13);
        for (int p = 1; p <= 3; p++) begin
            pointP1 = 1'b1;
            step(1);
            pointP1 = 1'b0;
            tests++;
            if (scoreP1 !== 4'(p)) begin
                fails++;
                $display("[TB] FAIL win_score p=%0d got %0d want %0d", p, scoreP1, p);
            end
            if (p < 3) step(21);
        end
        step(5);
        tests++;
        if (stateO !== GAME_OVER || winner !== WINNER_P1 || scoreP1 !== 4'd3 || scoreP2 !== 4'd0 || ballRun !== 1'b0) begin
            fails++;
            $display("[TB] FAIL game_over got st=%0d win=%b s1=%0d s2=%0d run=%b want 5 01 3 0 0",
                     stateO, winner, scoreP1, scoreP2, ballRun);
        end
        doStart();
        tests++;
        if (stateO !== COUNTDOWN || scoreP1 !== 4'd0 || scoreP2 !== 4'd0 || winner !== WINNER_NONE || countdown !== 4'd3) begin
            fails++;
            $display("[TB] FAIL restart got st=%0d s1=%0d s2=%0d win=%b cd=%0d want 1 0 0 00 3",
                     stateO, scoreP1, scoreP2, winner, countdown);
        end
    endtask

    task automatic test_reset_mid();
        int serveSeen;
        step(4);
        tests++;
        if (countdown !== 4'd2) begin
            fails++;
            $display("[TB] FAIL mid_countdown got %0d want 2", countdown);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        tests++;
        if ({ballRun, ballServe, serveDir, scoreP1, scoreP2, countdown, stateO, winner} !== 20'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid got run=%b serve=%b cd=%0d st=%0d want all 0",
                     ballRun, ballServe, countdown, stateO);
        end
        serveSeen = 0;
        for (int k = 0; k < 12; k++) begin
            if (ballServe !== 1'b0 || stateO !== IDLE) serveSeen++;
            step(1);
        end
        tests++;
        if (serveSeen !== 0) begin
            fails++;
            $display("[TB] FAIL reset_no_serve got %0d bad cycles want 0", serveSeen);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_point();
        test_simultaneous();
        test_pause();
        test_win_restart();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
